alpha2xinitial_axis: RTL and testbench

//   Multi-channel streaming argmax with AXI-Stream-style handshakes on both sides.

---
 rtl/alpha2x_pkg.sv | 16 +
 rtl/alpha2xinitial_axis_argmax_lane.sv | 60 ++++++
 rtl/alpha2xinitial_axis.sv | 129 ++++++++++++
 tb/tb_alpha2xinitial_axis.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alpha2x_pkg.sv
// Shared constants and helpers for the alpha -> initial-x argmax block.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package alpha2x_pkg;

  // Index width able to hold every candidate index 0..A-1, plus one spare bit.
  function automatic int awidth(input int a);
    return $clog2(a) + 1;
  endfunction

  // Bit positions inside x_initial_tuser.
  localparam int TUSER_SHORT  = 0;  // group closed by tlast before A beats
  localparam int TUSER_NOLAST = 1;  // A beats seen without tlast, group force-closed
  localparam int TUSER_W      = 2;

endpackage

// File: rtl/alpha2xinitial_axis_argmax_lane.sv
// One channel of the running argmax: holds best value/index across a group.
// Latency: idx (and best) are combinational results including the current beat.
// Backpressure: none; the top only asserts en on accepted beats.
// Optional: MAXVAL_OUT_EN exposes the winning value on port best.
module argmax_lane #(
  parameter int DATAWIDTH = 16,
  parameter int AWIDTH    = 2,
  parameter int SIGNED_IN = 1,
  parameter int TIE_LAST  = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATAWIDTH-1:0] din,
  input  logic                 first,
  input  logic                 en,
  input  logic [AWIDTH-1:0]    k,
  output logic [AWIDTH-1:0]    idx
`ifdef MAXVAL_OUT_EN
  ,
  output logic [DATAWIDTH-1:0] best
`endif
);

  logic [DATAWIDTH-1:0] best_q, best_d;
  logic [AWIDTH-1:0]    idx_q, idx_d;
  logic                 beats;

  // Compare the new sample against the running best; first beat of a group always wins.
  always_comb begin
    if (SIGNED_IN != 0) begin
      beats = (TIE_LAST != 0) ? ($signed(din) >= $signed(best_q))
                              : ($signed(din) >  $signed(best_q));
    end else begin
      beats = (TIE_LAST != 0) ? (din >= best_q) : (din > best_q);
    end
    best_d = best_q;
    idx_d  = idx_q;
    if (en && (first || beats)) begin
      best_d = din;
      idx_d  = k;
    end
  end

  // Running best/index state.
  always_ff @(posedge clk) begin
    if (rst) begin
      best_q <= '0;
      idx_q  <= '0;
    end else begin
      best_q <= best_d;
      idx_q  <= idx_d;
    end
  end

  assign idx = idx_d;
`ifdef MAXVAL_OUT_EN
  assign best = best_d;
`endif

endmodule

// File: rtl/alpha2xinitial_axis.sv
// Multi-channel streaming argmax: per lane, index of the largest alpha over an A-beat group.
// Latency: result valid 1 cycle after the group's final beat; back-to-back groups allowed.
// Backpressure: input ready = !out_valid | out_ready, so a held result stalls the input.
// Optional: MAXVAL_OUT_EN adds x_initial_maxval carrying each lane's winning value.
module alpha2xinitial_axis
  import alpha2x_pkg::*;
#(
  parameter int J         = 14,
  parameter int A         = 2,
  parameter int DATAWIDTH = 16,
  parameter int SIGNED_IN = 1,
  parameter int TIE_LAST  = 0,
  localparam int AWIDTH   = awidth(A)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [J*DATAWIDTH-1:0] alpha_u_col,
  input  logic                   alpha_u_col_tvalid,
  input  logic                   alpha_u_col_tlast,
  output logic                   alpha_u_col_tready,
  output logic [J*AWIDTH-1:0]    x_initial,
  output logic [TUSER_W-1:0]     x_initial_tuser,
  output logic                   x_initial_tvalid,
  input  logic                   x_initial_tready
`ifdef MAXVAL_OUT_EN
  ,
  output logic [J*DATAWIDTH-1:0] x_initial_maxval
`endif
);

  localparam logic [AWIDTH-1:0] K_LAST = AWIDTH'(A - 1);

  logic [AWIDTH-1:0]   k_q, k_d;
  logic [J*AWIDTH-1:0] x_q, x_d, lane_idx;
  logic [TUSER_W-1:0]  tuser_q, tuser_d;
  logic                vld_q, vld_d;
  logic                in_rdy, in_acc, last_k, grp_end;

  assign in_rdy  = !vld_q || x_initial_tready;
  assign in_acc  = alpha_u_col_tvalid && in_rdy;
  assign last_k  = (k_q == K_LAST);
  assign grp_end = in_acc && (alpha_u_col_tlast || last_k);

`ifdef MAXVAL_OUT_EN
  logic [J*DATAWIDTH-1:0] lane_best, maxval_q, maxval_d;
`endif

  for (genvar j = 0; j < J; j++) begin : g_lane
    argmax_lane #(
      .DATAWIDTH (DATAWIDTH),
      .AWIDTH    (AWIDTH),
      .SIGNED_IN (SIGNED_IN),
      .TIE_LAST  (TIE_LAST)
    ) u_lane (
      .clk   (clk),
      .rst   (rst),
      .din   (alpha_u_col[j*DATAWIDTH +: DATAWIDTH]),
      .first (k_q == '0),
      .en    (in_acc),
      .k     (k_q),
      .idx   (lane_idx[j*AWIDTH +: AWIDTH])
`ifdef MAXVAL_OUT_EN
      ,
      .best  (lane_best[j*DATAWIDTH +: DATAWIDTH])
`endif
    );
  end

  // Beat counter: advance on each accepted beat, wrap to 0 when a group closes.
  always_comb begin
    k_d = k_q;
    if (in_acc) begin
      k_d = grp_end ? '0 : k_q + 1'b1;
    end
  end

  // Output register: load on group end, otherwise drop valid once transferred.
  // A load can only happen when in_rdy is high, so it never overwrites a held result.
  always_comb begin
    x_d     = x_q;
    tuser_d = tuser_q;
    vld_d   = vld_q;
`ifdef MAXVAL_OUT_EN
    maxval_d = maxval_q;
`endif
    if (grp_end) begin
      x_d                  = lane_idx;
      tuser_d              = '0;
      tuser_d[TUSER_SHORT] = alpha_u_col_tlast && !last_k;
      tuser_d[TUSER_NOLAST] = last_k && !alpha_u_col_tlast;
      vld_d                = 1'b1;
`ifdef MAXVAL_OUT_EN
      maxval_d             = lane_best;
`endif
    end else if (vld_q && x_initial_tready) begin
      vld_d = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      k_q     <= '0;
      x_q     <= '0;
      tuser_q <= '0;
      vld_q   <= 1'b0;
`ifdef MAXVAL_OUT_EN
      maxval_q <= '0;
`endif
    end else begin
      k_q     <= k_d;
      x_q     <= x_d;
      tuser_q <= tuser_d;
      vld_q   <= vld_d;
`ifdef MAXVAL_OUT_EN
      maxval_q <= maxval_d;
`endif
    end
  end

  assign alpha_u_col_tready = in_rdy;
  assign x_initial          = x_q;
  assign x_initial_tuser    = tuser_q;
  assign x_initial_tvalid   = vld_q;
`ifdef MAXVAL_OUT_EN
  assign x_initial_maxval   = maxval_q;
`endif

endmodule

// File: tb/tb_alpha2xinitial_axis.sv
// Bench for alpha2xinitial_axis with J=2, A=2, DATAWIDTH=16: three instances share stimulus
// (signed strict-tie, signed tie-last, unsigned strict-tie); results checked via scoreboard.
module tb_alpha2xinitial_axis;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] col;
  logic        in_vld, in_last, out_rdy;

  logic        in_rdy_a, in_rdy_t, in_rdy_u;
  logic [3:0]  x_a, x_t, x_u;
  logic [1:0]  tu_a, tu_t, tu_u;
  logic        vld_a, vld_t, vld_u;
`ifdef MAXVAL_OUT_EN
  logic [31:0] mv_a, mv_t, mv_u;
`endif

  always #5 clk = ~clk;

  alpha2xinitial_axis #(.J(2), .A(2), .DATAWIDTH(16), .SIGNED_IN(1), .TIE_LAST(0)) dut (
    .clk(clk), .rst(rst), .alpha_u_col(col), .alpha_u_col_tvalid(in_vld),
    .alpha_u_col_tlast(in_last), .alpha_u_col_tready(in_rdy_a), .x_initial(x_a),
    .x_initial_tuser(tu_a), .x_initial_tvalid(vld_a), .x_initial_tready(out_rdy)
`ifdef MAXVAL_OUT_EN
    , .x_initial_maxval(mv_a)
`endif
  );

  alpha2xinitial_axis #(.J(2), .A(2), .DATAWIDTH(16), .SIGNED_IN(1), .TIE_LAST(1)) dut_tl (
    .clk(clk), .rst(rst), .alpha_u_col(col), .alpha_u_col_tvalid(in_vld),
    .alpha_u_col_tlast(in_last), .alpha_u_col_tready(in_rdy_t), .x_initial(x_t),
    .x_initial_tuser(tu_t), .x_initial_tvalid(vld_t), .x_initial_tready(out_rdy)
`ifdef MAXVAL_OUT_EN
    , .x_initial_maxval(mv_t)
`endif
  );

  alpha2xinitial_axis #(.J(2), .A(2), .DATAWIDTH(16), .SIGNED_IN(0), .TIE_LAST(0)) dut_us (
    .clk(clk), .rst(rst), .alpha_u_col(col), .alpha_u_col_tvalid(in_vld),
    .alpha_u_col_tlast(in_last), .alpha_u_col_tready(in_rdy_u), .x_initial(x_u),
    .x_initial_tuser(tu_u), .x_initial_tvalid(vld_u), .x_initial_tready(out_rdy)
`ifdef MAXVAL_OUT_EN
    , .x_initial_maxval(mv_u)
`endif
  );

  // Expected result: x = {lane1 idx, lane0 idx} for each instance, tuser, maxval {lane1, lane0}.
  typedef struct {
    logic [3:0]  x;
    logic [3:0]  xt;
    logic [3:0]  xu;
    logic [1:0]  tu;
    logic [31:0] mv;
  } exp_t;

  typedef struct {
    logic [15:0] a0, a1;   // lane0 beats
    logic [15:0] b0, b1;   // lane1 beats
    int          nb;       // beats in group (tlast on the last one)
    exp_t        e;
  } vec_t;

  exp_t   sb[$];
  int     xfer_cyc[$];
  int     cyc = 0;
  int     n_chk = 0;
  int     n_fail = 0;
  vec_t   vec [5];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard consumer: compare every transferred result against the queue head.
  always @(negedge clk) begin
    if (!rst && vld_a && out_rdy) begin
      xfer_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_output: x=%0h tuser=%0h with empty scoreboard", x_a, tu_a);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("x_signed", {28'd0, x_a}, {28'd0, e.x});
        chk("x_tielast", {28'd0, x_t}, {28'd0, e.xt});
        chk("x_unsigned", {28'd0, x_u}, {28'd0, e.xu});
        chk("tuser", {30'd0, tu_a}, {30'd0, e.tu});
        chk("vld_tielast", {31'd0, vld_t}, 32'd1);
        chk("vld_unsigned", {31'd0, vld_u}, 32'd1);
`ifdef MAXVAL_OUT_EN
        chk("maxval", mv_a, e.mv);
`endif
      end
    end
  end

  // Present one beat and hold it until accepted; returns just after the accepting edge.
  task automatic send_beat(input logic [15:0] l0, input logic [15:0] l1, input logic last);
    int t;
    col = {l1, l0};
    in_last = last;
    in_vld = 1'b1;
    t = 0;
    @(negedge clk);
    while (!in_rdy_a && t < 100) begin
      t++;
      @(negedge clk);
    end
    if (t >= 100) begin
      n_chk++;
      n_fail++;
      $display("FAIL accept_timeout: tready stuck low, got 0 expected 1");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_vld = 1'b0;
    in_last = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() > 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("scoreboard_drained", sb.size(), 32'd0);
  endtask

  initial begin
    exp_t e;
    vec[0] = '{16'd5, 16'd9, 16'hFFFD, 16'hFFF9, 2,
               '{4'b0001, 4'b0001, 4'b0001, 2'b00, 32'hFFFD_0009}};
    vec[1] = '{16'd4, 16'd4, 16'h8000, 16'h0001, 2,
               '{4'b0100, 4'b0101, 4'b0000, 2'b00, 32'h0001_0004}};
    vec[2] = '{16'hFFFF, 16'd0, 16'd100, 16'd100, 2,
               '{4'b0001, 4'b0101, 4'b0000, 2'b00, 32'h0064_0000}};
    vec[3] = '{16'd7, 16'hFFF8, 16'h7FFF, 16'h8000, 2,
               '{4'b0000, 4'b0000, 4'b0101, 2'b00, 32'h7FFF_0007}};
    vec[4] = '{16'd3, 16'd0, 16'hFFFE, 16'd0, 1,
               '{4'b0000, 4'b0000, 4'b0000, 2'b01, 32'hFFFE_0003}};

    rst = 1'b1; col = '0; in_vld = 1'b0; in_last = 1'b0; out_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_x", {28'd0, x_a}, 32'd0);
    chk("reset_tuser", {30'd0, tu_a}, 32'd0);
    chk("reset_tvalid", {31'd0, vld_a}, 32'd0);
    chk("reset_tready", {31'd0, in_rdy_a}, 32'd1);

    // Table-driven groups, with latency check on every 2-beat group.
    for (int i = 0; i < 5; i++) begin
      idle(2);
      if (vec[i].nb == 2) begin
        send_beat(vec[i].a0, vec[i].b0, 1'b0);
        chk("no_early_valid", {31'd0, vld_a}, 32'd0);
        sb.push_back(vec[i].e);
        send_beat(vec[i].a1, vec[i].b1, 1'b1);
      end else begin
        sb.push_back(vec[i].e);
        send_beat(vec[i].a0, vec[i].b0, 1'b1);
      end
      chk("latency_valid", {31'd0, vld_a}, 32'd1);
    end
    idle(2);
    drain();

    // Backpressure: result held for 5 cycles with input stalled, then released.
    out_rdy = 1'b0;
    send_beat(16'd10, 16'd30, 1'b0);
    e = '{4'b0001, 4'b0001, 4'b0101, 2'b00, 32'h001E_0014};
    sb.push_back(e);
    send_beat(16'd20, 16'hFFD8, 1'b1);
    col = {16'd1, 16'd1};
    in_last = 1'b0;
    in_vld = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("hold_x", {28'd0, x_a}, 32'h1);
      chk("hold_tvalid", {31'd0, vld_a}, 32'd1);
      chk("hold_in_tready", {31'd0, in_rdy_a}, 32'd0);
    end
    @(posedge clk);
    #1;
    out_rdy = 1'b1;
    @(posedge clk);
    #1;
    e = '{4'b0001, 4'b0001, 4'b0001, 2'b00, 32'h0001_0002};
    sb.push_back(e);
    send_beat(16'd2, 16'd0, 1'b1);
    idle(2);
    drain();

    // Back-to-back groups: one result every 2 cycles.
    xfer_cyc.delete();
    for (int g = 0; g < 3; g++) begin
      send_beat(16'(g), 16'd5, 1'b0);
      e = '{4'b0001, 4'b0001, 4'b0001, 2'b00, {16'd5, 16'(g + 5)}};
      sb.push_back(e);
      send_beat(16'(g + 5), 16'd1, 1'b1);
    end
    idle(3);
    drain();
    chk("b2b_count", xfer_cyc.size(), 32'd3);
    if (xfer_cyc.size() == 3) begin
      chk("b2b_gap0", xfer_cyc[1] - xfer_cyc[0], 32'd2);
      chk("b2b_gap1", xfer_cyc[2] - xfer_cyc[1], 32'd2);
    end

    // Framing: two beats without tlast force-close; the third beat opens a new group.
    idle(2);
    send_beat(16'd1, 16'd2, 1'b0);
    e = '{4'b0001, 4'b0001, 4'b0001, 2'b10, 32'h0002_0005};
    sb.push_back(e);
    send_beat(16'd5, 16'd0, 1'b0);
    e = '{4'b0000, 4'b0000, 4'b0000, 2'b01, 32'h0003_0003};
    sb.push_back(e);
    send_beat(16'd3, 16'd3, 1'b1);
    idle(2);
    drain();

    // Reset mid-group: partial group discarded, outputs cleared, next group correct.
    send_beat(16'd100, 16'd100, 1'b0);
    in_vld = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) begin
      chk("rst_mid_tvalid", {31'd0, vld_a}, 32'd0);
      chk("rst_mid_x", {28'd0, x_a}, 32'd0);
      chk("rst_mid_tuser", {30'd0, tu_a}, 32'd0);
      idle(1);
    end
    send_beat(16'd1, 16'd9, 1'b0);
    e = '{4'b0001, 4'b0001, 4'b0001, 2'b00, 32'h0009_0002};
    sb.push_back(e);
    send_beat(16'd2, 16'd8, 1'b1);
    idle(2);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
